click_merge_rr: RTL and testbench

- N-channel, clocked successor of the two-input click merge.
- Merges N_CH two-phase (transition-signalled) bundled-data input channels onto one two-phase output channel.
- Arbitration is fixed-priority or round-robin; output data is registered and tagged with the source channel.
- Sits at the boundary where asynchronous click pipelines feed a synchronous consumer domain. Asynchronous req/ack inputs are synchronised internally.

---
 rtl/click_merge_rr.sv | 143 ++++++++++++++
 tb/tb_click_merge_rr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/click_merge_rr.sv
// N-channel two-phase click merge onto one two-phase output channel.
// Requests and the output acknowledge are synchronised into clk; the winning
// token's data is registered and tagged with its source channel.
module click_merge_rr #(
    parameter int unsigned     N_CH           = 2,
    parameter int unsigned     DATA_W         = 8,
    parameter int unsigned     SYNC_STAGES    = 2,
    parameter int unsigned     ARB_MODE       = 1,
    parameter logic [N_CH-1:0] PHASE_INIT_IN  = '0,
    parameter logic            PHASE_INIT_OUT = 1'b0,
    localparam int unsigned    CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_req,
    output logic [N_CH-1:0]        in_ack,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic                   out_req,
    input  logic                   out_ack,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   busy,
    output logic [15:0]            xfer_cnt
);

    logic [N_CH-1:0]   req_s;
    logic              ack_s;

    logic [N_CH-1:0]   in_ack_q, in_ack_d;
    logic              out_req_q, out_req_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic [N_CH-1:0]   tok;
    logic              found;
    logic [CH_W-1:0]   win;
    logic              capture;

    // Synchronisers preset to the init phases so release of reset shows no token.
    if (SYNC_STAGES == 0) begin : g_bypass
        assign req_s = in_req;
        assign ack_s = out_ack;
    end else begin : g_sync
        logic [N_CH-1:0]        req_sync_q [SYNC_STAGES];
        logic [SYNC_STAGES-1:0] ack_sync_q;

        // Shift the raw handshake inputs through the synchroniser chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                    req_sync_q[i] <= PHASE_INIT_IN;
                end
                ack_sync_q <= {SYNC_STAGES{PHASE_INIT_OUT}};
            end else begin
                req_sync_q[0] <= in_req;
                ack_sync_q[0] <= out_ack;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    req_sync_q[i] <= req_sync_q[i-1];
                    ack_sync_q[i] <= ack_sync_q[i-1];
                end
            end
        end

        assign req_s = req_sync_q[SYNC_STAGES-1];
        assign ack_s = ack_sync_q[SYNC_STAGES-1];
    end

    assign tok     = req_s ^ in_ack_q;
    assign busy    = (out_req_q != ack_s);
    assign capture = !busy && found;

    // Pick the winning token: lowest index, or first after the last winner.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!found && tok[i]) begin
                    found = 1'b1;
                    win   = CH_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= int'(N_CH); k++) begin
                idx = (int'(ptr_q) + k) % int'(N_CH);
                if (!found && tok[idx]) begin
                    found = 1'b1;
                    win   = CH_W'(idx);
                end
            end
        end
    end

    // Next state: hold everything unless a capture happens on this edge.
    always_comb begin
        in_ack_d   = in_ack_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        xfer_cnt_d = xfer_cnt_q;
        ptr_d      = ptr_q;
        if (capture) begin
            in_ack_d   = in_ack_q ^ (N_CH'(1) << win);
            out_req_d  = ~out_req_q;
            out_data_d = in_data[int'(win)*int'(DATA_W) +: DATA_W];
            out_ch_d   = (N_CH > 1) ? win : '0;
            xfer_cnt_d = xfer_cnt_q + 16'd1;
            if (ARB_MODE != 0) begin
                ptr_d = win;
            end
        end
    end

    // Handshake, data and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ack_q   <= PHASE_INIT_IN;
            out_req_q  <= PHASE_INIT_OUT;
            out_data_q <= '0;
            out_ch_q   <= '0;
            xfer_cnt_q <= '0;
            ptr_q      <= CH_W'(N_CH - 1);
        end else begin
            in_ack_q   <= in_ack_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            xfer_cnt_q <= xfer_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign in_ack   = in_ack_q;
    assign out_req  = out_req_q;
    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_click_merge_rr.sv
// Bench for click_merge_rr: a round-robin instance with two-stage synchronisers
// and a fixed-priority instance with bypassed synchronisers.
module tb_click_merge_rr;

    localparam int N = 4;

    logic clk;
    logic rr_rst_n, fp_rst_n;

    logic [3:0]  rr_in_req, rr_in_ack;
    logic [31:0] rr_in_data;
    logic        rr_out_req, rr_out_ack, rr_busy;
    logic [7:0]  rr_out_data;
    logic [1:0]  rr_out_ch;
    logic [15:0] rr_xfer;

    logic [3:0]  fp_in_req, fp_in_ack;
    logic [31:0] fp_in_data;
    logic        fp_out_req, fp_out_ack, fp_busy;
    logic [7:0]  fp_out_data;
    logic [1:0]  fp_out_ch;
    logic [15:0] fp_xfer;

    int checks   = 0;
    int failures = 0;

    // Reference model state for the round-robin instance.
    logic [3:0] m_ack;
    logic       m_out_req;
    logic [7:0] m_out_data;
    logic [1:0] m_out_ch;
    int         m_cnt;
    int         m_last;
    int         m_win;
    logic [7:0] m_data [4];

    click_merge_rr #(
        .N_CH(4), .DATA_W(8), .SYNC_STAGES(2), .ARB_MODE(1),
        .PHASE_INIT_IN(4'b0101), .PHASE_INIT_OUT(1'b1)
    ) dut_rr (
        .clk(clk), .rst_n(rr_rst_n), .in_req(rr_in_req), .in_ack(rr_in_ack),
        .in_data(rr_in_data), .out_req(rr_out_req), .out_ack(rr_out_ack),
        .out_data(rr_out_data), .out_ch(rr_out_ch), .busy(rr_busy), .xfer_cnt(rr_xfer)
    );

    click_merge_rr #(
        .N_CH(4), .DATA_W(8), .SYNC_STAGES(0), .ARB_MODE(0),
        .PHASE_INIT_IN(4'b0000), .PHASE_INIT_OUT(1'b0)
    ) dut_fp (
        .clk(clk), .rst_n(fp_rst_n), .in_req(fp_in_req), .in_ack(fp_in_ack),
        .in_data(fp_in_data), .out_req(fp_out_req), .out_ack(fp_out_ack),
        .out_data(fp_out_data), .out_ch(fp_out_ch), .busy(fp_busy), .xfer_cnt(fp_xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ack      = 4'b0101;
        m_out_req  = 1'b1;
        m_out_data = 8'h00;
        m_out_ch   = 2'd0;
        m_cnt      = 0;
        m_last     = N - 1;
        m_win      = -1;
    endfunction

    // If the output is free, the first pending channel after the last winner is taken.
    function automatic void model_capture();
        int c;
        m_win = -1;
        if (m_out_req != rr_out_ack) return;
        for (int d = 1; d <= N; d++) begin
            c = (m_last + d) % N;
            if (m_win < 0 && rr_in_req[c] != m_ack[c]) m_win = c;
        end
        if (m_win < 0) return;
        m_out_req         = ~m_out_req;
        m_ack[m_win]      = ~m_ack[m_win];
        m_out_data        = m_data[m_win];
        m_out_ch          = 2'(m_win);
        m_cnt             = (m_cnt + 1) % 65536;
        m_last            = m_win;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rr_check(input string tag);
        chk({tag, "_in_ack"}, 32'(rr_in_ack), 32'(m_ack));
        chk({tag, "_out_req"}, 32'(rr_out_req), 32'(m_out_req));
        chk({tag, "_out_data"}, 32'(rr_out_data), 32'(m_out_data));
        chk({tag, "_out_ch"}, 32'(rr_out_ch), 32'(m_out_ch));
        chk({tag, "_busy"}, 32'(rr_busy), 32'(m_out_req != rr_out_ack));
        chk({tag, "_xfer"}, 32'(rr_xfer), 32'(m_cnt));
    endtask

    // New tokens on the masked channels that are not already pending.
    task automatic rr_add(input logic [3:0] mask);
        logic [7:0] v;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && rr_in_req[i] == m_ack[i]) begin
                v                    = 8'($urandom);
                m_data[i]            = v;
                rr_in_data[i*8 +: 8] = v;
                rr_in_req[i]         = ~rr_in_req[i];
            end
        end
        model_capture();
        cycles(4);
        rr_check("rr_add");
    endtask

    task automatic rr_ackout();
        if (rr_out_ack != m_out_req) rr_out_ack = m_out_req;
        model_capture();
        cycles(4);
        rr_check("rr_ack");
    endtask

    initial begin
        logic prev_req;
        rr_rst_n   = 1'b0;
        fp_rst_n   = 1'b0;
        rr_in_req  = 4'b0101;
        rr_out_ack = 1'b1;
        rr_in_data = 32'h0;
        fp_in_req  = 4'b0000;
        fp_out_ack = 1'b0;
        fp_in_data = 32'h0;
        for (int i = 0; i < N; i++) m_data[i] = 8'h00;
        model_reset();

        // Reset values
        cycles(3);
        chk("rst_in_ack", 32'(rr_in_ack), 32'h5);
        chk("rst_out_req", 32'(rr_out_req), 32'h1);
        chk("rst_out_data", 32'(rr_out_data), 32'h0);
        chk("rst_out_ch", 32'(rr_out_ch), 32'h0);
        chk("rst_xfer", 32'(rr_xfer), 32'h0);
        chk("rst_busy", 32'(rr_busy), 32'h0);
        rr_rst_n = 1'b1;
        fp_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            chk("idle_in_ack", 32'(rr_in_ack), 32'h5);
            chk("idle_out_req", 32'(rr_out_req), 32'h1);
            chk("idle_xfer", 32'(rr_xfer), 32'h0);
        end
        chk("fp_idle_busy", 32'(fp_busy), 32'h0);

        // Round-robin fairness: all four pending, order 0,1,2,3 then 0 again
        rr_add(4'hF);
        chk("rr_order_0", 32'(rr_out_ch), 32'd0);
        for (int j = 1; j < N; j++) begin
            rr_ackout();
            chk("rr_order_n", 32'(rr_out_ch), 32'(j));
        end
        rr_ackout();
        chk("rr_round_acks", 32'(rr_in_ack), 32'hA);
        chk("rr_round_idle", 32'(rr_busy), 32'h0);
        rr_add(4'b0001);
        chk("rr_order_wrap", 32'(rr_out_ch), 32'd0);
        rr_ackout();

        // Single transfer latency: toggle before edge k, capture at edge k+2
        rr_in_data[23:16] = 8'hA5;
        m_data[2]         = 8'hA5;
        rr_in_req[2]      = ~rr_in_req[2];
        prev_req          = m_out_req;
        cycles(2);
        chk("lat_early_req", 32'(rr_out_req), 32'(prev_req));
        chk("lat_early_ack", 32'(rr_in_ack), 32'(m_ack));
        model_capture();
        cycles(1);
        rr_check("lat");
        chk("lat_data", 32'(rr_out_data), 32'hA5);
        chk("lat_ch", 32'(rr_out_ch), 32'd2);
        chk("lat_busy", 32'(rr_busy), 32'h1);
        rr_out_ack = ~rr_out_ack;
        model_capture();
        cycles(1);
        chk("ack_busy_1", 32'(rr_busy), 32'h1);
        cycles(1);
        chk("ack_busy_2", 32'(rr_busy), 32'h0);

        // Back-pressure: three tokens, no ack -> exactly one capture
        rr_add(4'b1011);
        cycles(10);
        rr_check("bp_hold");

        // Reset mid-operation, busy with two tokens pending
        chk("mid_busy", 32'(rr_busy), 32'h1);
        @(posedge clk);
        #2 rr_rst_n = 1'b0;
        #1;
        chk("mid_in_ack", 32'(rr_in_ack), 32'h5);
        chk("mid_out_req", 32'(rr_out_req), 32'h1);
        chk("mid_out_data", 32'(rr_out_data), 32'h0);
        chk("mid_out_ch", 32'(rr_out_ch), 32'h0);
        chk("mid_xfer", 32'(rr_xfer), 32'h0);
        chk("mid_busy_rst", 32'(rr_busy), 32'h0);
        rr_in_req  = 4'b0101;
        rr_out_ack = 1'b1;
        model_reset();
        cycles(2);
        rr_rst_n = 1'b1;
        cycles(4);
        rr_check("post_rst");

        // Randomised mix of new tokens and output acknowledges
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) rr_add(4'($urandom));
            else rr_ackout();
        end

        // Fixed priority: channels 1 and 3 pending, 1 wins, re-asserted 1 wins again
        fp_in_data[15:8]  = 8'h11;
        fp_in_data[31:24] = 8'h33;
        fp_in_req         = 4'b1010;
        cycles(1);
        chk("fp_first_ch", 32'(fp_out_ch), 32'd1);
        chk("fp_first_data", 32'(fp_out_data), 32'h11);
        chk("fp_first_ack", 32'(fp_in_ack), 32'h2);
        chk("fp_first_busy", 32'(fp_busy), 32'h1);
        cycles(3);
        chk("fp_hold_ack", 32'(fp_in_ack), 32'h2);
        fp_in_data[15:8] = 8'h22;
        fp_in_req[1]     = ~fp_in_req[1];
        fp_out_ack       = 1'b1;
        cycles(1);
        chk("fp_again_ch", 32'(fp_out_ch), 32'd1);
        chk("fp_again_data", 32'(fp_out_data), 32'h22);
        chk("fp_again_ack", 32'(fp_in_ack), 32'h0);
        fp_out_ack = 1'b0;
        cycles(1);
        chk("fp_last_ch", 32'(fp_out_ch), 32'd3);
        chk("fp_last_data", 32'(fp_out_data), 32'h33);
        chk("fp_last_ack", 32'(fp_in_ack), 32'h8);
        chk("fp_last_xfer", 32'(fp_xfer), 32'd3);

        // Counter wrap: one capture per edge on channel 0 with the ack echoed at once
        for (int i = 0; i < 65533 + 1000; i++) begin
            if (fp_out_ack != fp_out_req) fp_out_ack = fp_out_req;
            if (fp_in_req[0] == fp_in_ack[0]) fp_in_req[0] = ~fp_in_req[0];
            cycles(1);
            if (i == 65532) chk("wrap_zero", 32'(fp_xfer), 32'd0);
        end
        chk("wrap_past", 32'(fp_xfer), 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
